serial_adder_ctrl: RTL and testbench

Bit-serial add/subtract sequencer built around one instance of the existing FullAdder cell (ports a, b, c, sum, carry). It accepts two WIDTH-bit operands over a valid/ready handshake and feeds one bit pair per clock, LSB first, through the cell. A carry flip-flop links the bits. The result, carry-out and signed overflow are returned over a second valid/ready handshake. It is the area-minimal arithmetic option for the hack datapath: one adder cell instead of a WIDTH-bit ripple chain.

---
 rtl/arith_pkg.sv | 23 ++
 rtl/FullAdder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 104 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// a width helper for sizing counters.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/FullAdder.sv
// One-bit full adder cell shared by the serial arithmetic datapath.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one FullAdder cell processes one bit pair
// per clock, LSB first, with a carry flip-flop linking successive bits.
module serial_adder_ctrl
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-2:0]   sum_sh;
    logic [WIDTH-1:0]   sum_cat;
    logic               cell_sum;
    logic               cell_carry;
    logic               accept;

    FullAdder u_cell (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c     (carry),
        .sum   (cell_sum),
        .carry (cell_carry)
    );

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready & ~flush;

    // The newest sum bit enters at the top; after the last bit this is the full result.
    assign sum_cat = {cell_sum, sum_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            carry    <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Subtraction is a + ~b + ~borrow_in.
                        a_sh  <= a;
                        b_sh  <= b ^ {WIDTH{sub}};
                        carry <= cin ^ sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_cat[WIDTH-1:1];
                    carry  <= cell_carry;
                    if (cnt == LAST_BIT) begin
                        sum      <= sum_cat;
                        cout     <= cell_carry;
                        overflow <= carry ^ cell_carry;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized and directed bench for serial_adder_ctrl against an arithmetic reference model.
module tb_serial_adder_ctrl;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int n_tests;
    int n_fail;

    logic [W-1:0] last_sum;
    logic         last_cout;
    logic         last_ovf;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned result/carry and signed range test.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic c, input logic s,
                                  output logic [W-1:0] r, output logic co, output logic ov);
        longint ux, uy, sx, sy, full, sres, lim;
        lim = longint'(1) << W;
        ux  = longint'(x);
        uy  = longint'(y);
        sx  = (ux >= lim / 2) ? ux - lim : ux;
        sy  = (uy >= lim / 2) ? uy - lim : uy;
        if (!s) begin
            full = ux + uy + longint'(c);
            co   = (full >= lim);
            sres = sx + sy + longint'(c);
        end else begin
            full = ux - uy - longint'(c);
            co   = (ux >= uy + longint'(c));
            sres = sx - sy - longint'(c);
        end
        r  = full[W-1:0];
        ov = (sres > lim / 2 - 1) || (sres < -(lim / 2));
    endfunction

    // Accept one operation and wait (bounded) until its result is presented.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tcin, input logic tsub, input string tag);
        logic [W-1:0] es;
        logic         ec, eo;
        int           lat, busy_cnt;
        model(ta, tb, tcin, tsub, es, ec, eo);
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
        check({tag, "_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        busy_cnt = 0;
        while (!out_valid && lat < W + 4) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(W));
        check({tag, "_busy"}, 64'(busy_cnt), 64'(W));
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        check({tag, "_ovf"}, 64'(overflow), 64'(eo));
        last_sum  = es;
        last_cout = ec;
        last_ovf  = eo;
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tcin, input logic tsub, input string tag);
        launch(ta, tb, tcin, tsub, tag);
        @(posedge clk); #1;
        check({tag, "_idle"}, 64'(in_ready), 64'(1));
        check({tag, "_ovld"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        int seen;
        n_tests = 0;
        n_fail = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
        #1;
        check("rst_ready", 64'(in_ready), 64'(1));
        check("rst_ovld", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, "add_basic");
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_wrap");
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "add_cin");
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, "sub_neg");
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");
        do_op(16'h0010, 16'h0001, 1'b1, 1'b1, "sub_bin");

        // Backpressure: result held while the consumer stalls and new requests wait.
        out_ready = 1'b0;
        launch(16'h0F0F, 16'h00F1, 1'b0, 1'b0, "bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
            check("bp_ovld", 64'(out_valid), 64'(1));
            check("bp_ready", 64'(in_ready), 64'(0));
            check("bp_sum", 64'(sum), 64'(last_sum));
            check("bp_cout", 64'(cout), 64'(last_cout));
            check("bp_ovf", 64'(overflow), 64'(last_ovf));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 64'(in_ready), 64'(1));
        do_op(16'h0001, 16'h0002, 1'b0, 1'b0, "bp_next");

        // Flush in the middle of a run.
        a = 16'hAAAA; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_ready", 64'(in_ready), 64'(1));
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_sum", 64'(sum), 64'(last_sum));
        check("flush_cout", 64'(cout), 64'(last_cout));
        seen = 0;
        repeat (W + 2) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush_nopulse", 64'(seen), 64'(0));

        // Flush beats a simultaneous request.
        a = 16'h0003; b = 16'h0004; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_noacc_ready", 64'(in_ready), 64'(1));
        check("flush_noacc_busy", 64'(busy), 64'(0));

        // Flush together with out_ready in DONE drops the result.
        out_ready = 1'b0;
        launch(16'h1000, 16'h0234, 1'b1, 1'b1, "fd");
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fd_idle", 64'(in_ready), 64'(1));
        check("fd_ovld", 64'(out_valid), 64'(0));
        check("fd_sum", 64'(sum), 64'(last_sum));
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen++;
        end
        check("fd_quiet", 64'(seen), 64'(0));

        // Asynchronous reset partway through an add.
        a = 16'h5A5A; b = 16'h0101; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_ovld", 64'(out_valid), 64'(0));
        check("mrst_busy", 64'(busy), 64'(0));
        check("mrst_ready", 64'(in_ready), 64'(1));
        check("mrst_sum", 64'(sum), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(16'h2222, 16'h1111, 1'b0, 1'b1, "mrst_next");

        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
